plane_update_scheduler: RTL
===========================

Name: plane_update_scheduler

Overview:
- Periodic sequencer for the plane physics state update block.
- Generates a fixed-rate update tick from the system clock and snapshots pilot control inputs at the tick, so the physics block sees stable values for the whole update.
- Drives the `update_enable`/`update_done` handshake, then emits a one-cycle `state_valid` strobe so renderer/HUD logic can sample the new plane state.
- Detects missed ticks (overruns) and hung updates (timeouts).

Parameters:
- CLOCK_FREQUENCY, 166000000: clk frequency in Hz.
- UPDATE_MS, 100: tick interval in ms. PERIOD = CLOCK_FREQUENCY/1000*UPDATE_MS cycles, computed at elaboration; PERIOD must be >= 4.
- ANGLE_WIDTH, 16: width of the angle-rate inputs and outputs.
- TIMEOUT_CYCLES, 1024: maximum number of cycles `update_enable` stays high waiting for `update_done`.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = tick counter runs; 0 = paused
- clear_errors  in  1  pulse; clears `overrun_count` and `timeout_error`
- pitch_change_in  in  ANGLE_WIDTH  live pitch rate from the controls
- roll_change_in  in  ANGLE_WIDTH  live roll rate
- heading_change_in  in  ANGLE_WIDTH  live heading rate
- throttle_in  in  8  live throttle, 0-100
- update_enable  out  1  request to the physics block
- update_done  in  1  completion from the physics block
- pitch_change_out  out  ANGLE_WIDTH  snapshot value
- roll_change_out  out  ANGLE_WIDTH  snapshot value
- heading_change_out  out  ANGLE_WIDTH  snapshot value
- throttle_out  out  8  snapshot value
- state_valid  out  1  one-cycle strobe after a successful update
- busy  out  1  state != IDLE
- overrun_count  out  8  saturating count of dropped ticks
- timeout_error  out  1  sticky flag, set on a hung update

Behaviour:
- Tick counter tcnt:
  - Range 0..PERIOD-1. Increments each cycle while enable=1 and holds while enable=0.
  - Tick = (enable && tcnt==PERIOD-1); tcnt wraps to 0 on a tick.
  - Pausing does not abort an in-flight request.
- FSM states: IDLE, REQUEST, DONE.
  - `update_enable` = (state==REQUEST), decoded from the registered state.
  - `state_valid` = (state==DONE).
  - `busy` = (state!=IDLE).
- IDLE:
  - On a tick, go to REQUEST, latch all four `*_in` inputs into the `*_out` registers, and clear the wait counter wcnt.
  - `update_enable` therefore rises on the cycle after the tick cycle.
  - Snapshot outputs change only at this transition.
- REQUEST:
  - If update_done=1, go to DONE.
  - Else if wcnt==TIMEOUT_CYCLES-1, go to IDLE and set `timeout_error`; `state_valid` is not pulsed.
  - Else wcnt increments.
  - If update_done and the timeout condition occur in the same cycle, done wins.
  - `update_done` is ignored in IDLE and DONE.
- DONE: lasts exactly one cycle, then IDLE.
  - Minimum latency: tick at cycle T, `update_enable` high at T+1, `update_done` seen at T+1, `state_valid` high at T+2.
- Overrun:
  - A tick while state != IDLE is dropped. `overrun_count` increments, saturating at 255. The snapshot is untouched.
  - A tick in the same cycle as REQUEST->IDLE on timeout is also an overrun, because the state is not IDLE in that cycle.
- clear_errors:
  - Zeroes `overrun_count` and `timeout_error` on the next edge.
  - If an overrun or timeout occurs in the same cycle, the new event wins: count = 1 or flag = 1.
- Reset:
  - Sets state=IDLE, tcnt=0, wcnt=0, snapshot outputs=0, overrun_count=0, timeout_error=0.
  - All outputs are 0 after reset, including `update_enable`, `state_valid` and `busy`.
  - Reset during REQUEST drops `update_enable` on the next cycle; no `state_valid` is produced.
  - Reset has priority over all other inputs.
- Inputs are treated as synchronous to clk; no internal synchronisers.

Test Plan:
Bench parameters CLOCK_FREQUENCY=10000, UPDATE_MS=2 (PERIOD=20), TIMEOUT_CYCLES=8.
- Nominal update:
  - Stimulus: release reset, enable=1, inputs pitch=0x0005 and throttle=50; responder asserts done 3 cycles after `update_enable` rises.
  - Required: first `update_enable` at cycle 20 after reset release; `state_valid` exactly once, at cycle 24; snapshot = 0x0005/50; period between `state_valid` pulses = 20.
- Snapshot stability:
  - Stimulus: change pitch_change_in to 0x0100 while in REQUEST.
  - Required: pitch_change_out stays 0x0005 until the next tick, then becomes 0x0100.
- Timeout:
  - Stimulus: responder never asserts done.
  - Required: `update_enable` high for exactly 8 cycles; `timeout_error`=1 thereafter; no `state_valid`; the next tick starts a new request.
- Overrun:
  - Stimulus: responder delays done by 25 cycles (TIMEOUT_CYCLES raised to 64 for this test).
  - Required: the tick arriving during REQUEST gives overrun_count=1 and the snapshot is unchanged; clear_errors gives 0; 300 forced overruns give a count saturated at 255.
- Pause and boundaries:
  - Stimulus: enable=0 at tcnt=10 for 50 cycles.
  - Required: no tick during the pause; the next tick comes 9 cycles after enable returns to 1.
  - Done and timeout coincident at wcnt=7 gives `state_valid`=1 and timeout_error=0.
- Reset mid-request:
  - Stimulus: assert reset while `update_enable`=1.
  - Required: next cycle all outputs are 0 and no `state_valid` is generated.

Source files
------------

// File: rtl/plane_update_scheduler.sv
// Fixed-rate update sequencer: tick -> snapshot controls -> update_enable/update_done handshake -> one-cycle state_valid.
// update_enable rises 1 cycle after a tick; state_valid 1 cycle after done; ticks that arrive while busy are counted as overruns.
module plane_update_scheduler #(
  parameter int CLOCK_FREQUENCY = 166000000,
  parameter int UPDATE_MS       = 100,
  parameter int ANGLE_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear_errors,
  input  logic [ANGLE_WIDTH-1:0] pitch_change_in,
  input  logic [ANGLE_WIDTH-1:0] roll_change_in,
  input  logic [ANGLE_WIDTH-1:0] heading_change_in,
  input  logic [7:0]             throttle_in,
  output logic                   update_enable,
  input  logic                   update_done,
  output logic [ANGLE_WIDTH-1:0] pitch_change_out,
  output logic [ANGLE_WIDTH-1:0] roll_change_out,
  output logic [ANGLE_WIDTH-1:0] heading_change_out,
  output logic [7:0]             throttle_out,
  output logic                   state_valid,
  output logic                   busy,
  output logic [7:0]             overrun_count,
  output logic                   timeout_error
);

  localparam int PERIOD = CLOCK_FREQUENCY / 1000 * UPDATE_MS;
  localparam int TCW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int WCW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(PERIOD - 1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TCW-1:0]         r_tcnt;
  logic [WCW-1:0]         r_wcnt;
  logic [ANGLE_WIDTH-1:0] r_pitch;
  logic [ANGLE_WIDTH-1:0] r_roll;
  logic [ANGLE_WIDTH-1:0] r_heading;
  logic [7:0]             r_throttle;
  logic [7:0]             r_overrun;
  logic                   r_timeout;

  logic w_tick;
  logic w_start;
  logic w_overrun;
  logic w_timeout;
  logic w_update_enable;
  logic w_state_valid;
  logic w_busy;

  assign w_tick    = enable && (r_tcnt == TC_LAST);
  assign w_start   = w_tick && (r_state == S_IDLE);
  assign w_overrun = w_tick && (r_state != S_IDLE);
  // done wins over a timeout landing on the same cycle
  assign w_timeout = (r_state == S_REQUEST) && !update_done && (r_wcnt == WC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_update_enable = 1'b0;
    w_state_valid   = 1'b0;
    w_busy          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) w_state_nxt = S_REQUEST;
      end
      S_REQUEST: begin
        w_update_enable = 1'b1;
        w_busy          = 1'b1;
        if (update_done) begin
          w_state_nxt = S_DONE;
        end else if (r_wcnt == WC_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_valid = 1'b1;
        w_busy        = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick counter only advances while enabled; pausing leaves any request in flight untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (enable) begin
      if (r_tcnt == TC_LAST) r_tcnt <= '0;
      else                   r_tcnt <= r_tcnt + TCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= '0;
    end else if (w_start) begin
      r_wcnt <= '0;
    end else if ((r_state == S_REQUEST) && !update_done && (r_wcnt != WC_LAST)) begin
      r_wcnt <= r_wcnt + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pitch    <= '0;
      r_roll     <= '0;
      r_heading  <= '0;
      r_throttle <= '0;
    end else if (w_start) begin
      r_pitch    <= pitch_change_in;
      r_roll     <= roll_change_in;
      r_heading  <= heading_change_in;
      r_throttle <= throttle_in;
    end
  end

  // A new event in the same cycle as clear_errors survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= '0;
    end else if (clear_errors) begin
      r_overrun <= {7'd0, w_overrun};
    end else if (w_overrun && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_timeout <= 1'b1;
    end else if (clear_errors) begin
      r_timeout <= 1'b0;
    end
  end

  assign update_enable      = w_update_enable;
  assign state_valid        = w_state_valid;
  assign busy               = w_busy;
  assign pitch_change_out   = r_pitch;
  assign roll_change_out    = r_roll;
  assign heading_change_out = r_heading;
  assign throttle_out       = r_throttle;
  assign overrun_count      = r_overrun;
  assign timeout_error      = r_timeout;

endmodule
